// File: rtl/serial_cmd_dispatch.sv
// serial_cmd_dispatch: turns rx packets into register writes, register reads with tx readback, or slave-readback forwarding
module serial_cmd_dispatch #(
  parameter real TCQ = 0.1,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_TIMEOUT = 64,
  parameter logic [31:0] RD_DUMMY = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_valid_i,
  input  logic [31:0]           rx_data_i,
  output logic                  reg_wr_en_o,
  output logic                  reg_rd_en_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [31:0]           reg_wr_data_o,
  input  logic                  reg_rd_vld_i,
  input  logic [31:0]           reg_rd_data_i,
  output logic                  tx_valid_o,
  output logic [31:0]           tx_data_o,
  output logic                  tx_last_o,
  input  logic                  tx_ready_i,
  output logic                  rb_valid_o,
  output logic [31:0]           rb_data_o,
  output logic                  busy_o,
  output logic                  cmd_err_o,
  output logic                  rd_timeout_o
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR, RB, RD_HDR, RD_REQ, RD_WAIT, RD_SEND} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] ba;
  logic [4:0] nm1;
  logic [5:0] idx;
  logic [TW-1:0] tcnt;
  logic rx_prev, drop, last;
  assign last = idx[4:0] == nm1;
  if (TCQ < 0.0) begin : g_tcq_chk
    $error("TCQ must be non-negative");
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ba <= '0;
      nm1 <= '0;
      idx <= '0;
      tcnt <= '0;
      rx_prev <= 1'b0;
      drop <= 1'b0;
      reg_wr_en_o <= 1'b0;
      reg_rd_en_o <= 1'b0;
      reg_addr_o <= '0;
      reg_wr_data_o <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o <= '0;
      tx_last_o <= 1'b0;
      rb_valid_o <= 1'b0;
      rb_data_o <= '0;
      busy_o <= 1'b0;
      cmd_err_o <= 1'b0;
      rd_timeout_o <= 1'b0;
    end else begin
      rx_prev <= rx_valid_i;
      reg_wr_en_o <= 1'b0;
      reg_rd_en_o <= 1'b0;
      rb_valid_o <= 1'b0;
      cmd_err_o <= 1'b0;
      rd_timeout_o <= 1'b0;
      if (!rx_valid_i) drop <= 1'b0;
      case (state)
        IDLE:
          if (rx_valid_i && !rx_prev) begin
            ba <= ADDR_WIDTH'(rx_data_i[31:16]);
            nm1 <= rx_data_i[4:0];
            idx <= '0;
            tcnt <= '0;
            busy_o <= 1'b1;
            if (rx_data_i[15:12] == 4'b1010) begin
              state <= RB;
              rb_valid_o <= 1'b1;
              rb_data_o <= rx_data_i;
            end else state <= rx_data_i[7] ? RD_HDR : WR;
          end else if (rx_valid_i && !drop) begin
            cmd_err_o <= 1'b1;
            drop <= 1'b1;
          end
        WR:
          if (!rx_valid_i) begin
            cmd_err_o <= 1'b1;
            state <= IDLE;
            busy_o <= 1'b0;
          end else begin
            reg_wr_en_o <= 1'b1;
            reg_addr_o <= ba + ADDR_WIDTH'(idx);
            reg_wr_data_o <= rx_data_i;
            idx <= idx + 6'd1;
            if (last) begin
              state <= IDLE;
              busy_o <= 1'b0;
            end
          end
        RB:
          if (rx_valid_i) begin
            rb_valid_o <= 1'b1;
            rb_data_o <= rx_data_i;
          end else begin
            state <= IDLE;
            busy_o <= 1'b0;
          end
        RD_HDR:
          if (!tx_valid_o) begin
            tx_valid_o <= 1'b1;
            tx_data_o <= {16'(ba), 4'b1010, 7'd0, nm1};
            tx_last_o <= 1'b0;
          end else if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            reg_rd_en_o <= 1'b1;
            reg_addr_o <= ba + ADDR_WIDTH'(idx);
            state <= RD_REQ;
          end
        RD_REQ: begin
          tcnt <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT:
          if (reg_rd_vld_i || tcnt == TW'(RD_TIMEOUT)) begin
            tx_valid_o <= 1'b1;
            tx_data_o <= reg_rd_vld_i ? reg_rd_data_i : RD_DUMMY;
            tx_last_o <= last;
            rd_timeout_o <= !reg_rd_vld_i;
            state <= RD_SEND;
          end else tcnt <= tcnt + TW'(1);
        RD_SEND:
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            if (last) begin
              state <= IDLE;
              busy_o <= 1'b0;
            end else begin
              idx <= idx + 6'd1;
              reg_rd_en_o <= 1'b1;
              reg_addr_o <= ba + ADDR_WIDTH'(idx + 6'd1);
              state <= RD_REQ;
            end
          end
        default: begin
          state <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
      if (rx_valid_i && state inside {RD_HDR, RD_REQ, RD_WAIT, RD_SEND}) begin
        drop <= 1'b1;
        if (!rx_prev) cmd_err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_cmd_dispatch.sv
// tb_serial_cmd_dispatch: directed self-checking bench for serial_cmd_dispatch
module tb_serial_cmd_dispatch;
  logic clk_i = 1'b0;
  logic rst_i, rx_valid_i, reg_rd_vld_i, tx_ready_i;
  logic [31:0] rx_data_i, reg_rd_data_i;
  logic reg_wr_en_o, reg_rd_en_o, tx_valid_o, tx_last_o, rb_valid_o, busy_o, cmd_err_o, rd_timeout_o;
  logic [15:0] reg_addr_o, rsp_addr;
  logic [31:0] reg_wr_data_o, tx_data_o, rb_data_o;
  int n_cmp = 0, n_bad = 0, rd_lat = 0, w;
  always #5 clk_i = ~clk_i;
  serial_cmd_dispatch dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .reg_wr_en_o(reg_wr_en_o), .reg_rd_en_o(reg_rd_en_o), .reg_addr_o(reg_addr_o),
    .reg_wr_data_o(reg_wr_data_o), .reg_rd_vld_i(reg_rd_vld_i), .reg_rd_data_i(reg_rd_data_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_last_o(tx_last_o), .tx_ready_i(tx_ready_i),
    .rb_valid_o(rb_valid_o), .rb_data_o(rb_data_o), .busy_o(busy_o), .cmd_err_o(cmd_err_o),
    .rd_timeout_o(rd_timeout_o)
  );
  function automatic logic [31:0] dm(input logic [15:0] a);
    return {~a, a};
  endfunction
  function automatic logic [63:0] outs();
    return {8'(0), reg_wr_en_o, reg_rd_en_o, tx_valid_o, tx_last_o, rb_valid_o, busy_o, cmd_err_o,
            rd_timeout_o, reg_addr_o, tx_data_o};
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic rx(input logic v, input logic [31:0] d);
    rx_valid_i = v;
    rx_data_i = d;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic get_tx(input string tag, input logic [31:0] ed, input logic el, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!tx_valid_o && waited < 200);
    chk({tag, " valid"}, 64'(tx_valid_o), 64'(1));
    chk({tag, " data"}, 64'(tx_data_o), 64'(ed));
    chk({tag, " last"}, 64'(tx_last_o), 64'(el));
  endtask
  initial begin
    reg_rd_vld_i = 1'b0;
    reg_rd_data_i = '0;
    forever begin
      tick();
      if (reg_rd_en_o && rd_lat > 0) begin
        rsp_addr = reg_addr_o;
        repeat (rd_lat) @(posedge clk_i);
        #1;
        reg_rd_vld_i = 1'b1;
        reg_rd_data_i = dm(rsp_addr);
        tick();
        reg_rd_vld_i = 1'b0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_i = 1'b1;
    tx_ready_i = 1'b1;
    rx(0, 0);
    tick();
    tick();
    chk("reset outs", outs(), 0);
    rst_i = 1'b0;
    tick();
    rx(1, 32'h0100_0003);
    tick();
    chk("wr busy", 64'(busy_o), 1);
    for (int k = 0; k < 4; k++) begin
      rx(1, 32'hA0 + k);
      tick();
      chk("wr strobe", {reg_wr_en_o, cmd_err_o, reg_addr_o, reg_wr_data_o}, {2'b10, 16'(16'h0100 + k), 32'(32'hA0 + k)});
    end
    rx(0, 0);
    tick();
    chk("wr done", {reg_wr_en_o, busy_o, cmd_err_o}, 0);
    rx(1, 32'h0300_0000);
    tick();
    rx(1, 32'h11);
    tick();
    chk("long wr", {reg_wr_en_o, cmd_err_o, reg_addr_o}, {2'b10, 16'h0300});
    rx(1, 32'h22);
    tick();
    chk("long err", {reg_wr_en_o, cmd_err_o}, 2'b01);
    rx(1, 32'h33);
    tick();
    chk("long once", {reg_wr_en_o, cmd_err_o, busy_o}, 0);
    rx(0, 0);
    tick();
    rx(1, 32'h0400_0003);
    tick();
    rx(1, 32'hB0);
    tick();
    chk("short wr0", {reg_wr_en_o, reg_addr_o, reg_wr_data_o}, {1'b1, 16'h0400, 32'hB0});
    rx(1, 32'hB1);
    tick();
    chk("short wr1", {reg_wr_en_o, cmd_err_o, reg_addr_o, reg_wr_data_o}, {2'b10, 16'h0401, 32'hB1});
    rx(0, 0);
    tick();
    chk("short err", {reg_wr_en_o, cmd_err_o, busy_o}, 3'b010);
    tick();
    chk("short pulse", 64'(cmd_err_o), 0);
    rx(1, 32'h0480_0002);
    tick();
    rx(0, 0);
    tick();
    chk("hdr only err", {reg_wr_en_o, cmd_err_o, busy_o}, 3'b010);
    tick();
    rx(1, 32'h1234_A000);
    tick();
    chk("rb0", {rb_valid_o, reg_wr_en_o, reg_rd_en_o, rb_data_o}, {3'b100, 32'h1234_A000});
    rx(1, 32'h5555_5555);
    tick();
    chk("rb1", {rb_valid_o, reg_wr_en_o, reg_rd_en_o, rb_data_o}, {3'b100, 32'h5555_5555});
    rx(0, 0);
    tick();
    chk("rb end", {rb_valid_o, reg_wr_en_o, reg_rd_en_o, tx_valid_o, busy_o}, 0);
    rd_lat = 2;
    rx(1, 32'h0200_0081);
    tick();
    rx(0, 0);
    get_tx("rd hdr", 32'h0200_A001, 0, w);
    chk("rd hdr lat", 64'(w), 1);
    get_tx("rd d0", dm(16'h0200), 0, w);
    chk("rd d0 lat", 64'(w), 4);
    get_tx("rd d1", dm(16'h0201), 1, w);
    chk("rd d1 lat", 64'(w), 4);
    tick();
    chk("rd done", {tx_valid_o, busy_o, cmd_err_o}, 0);
    rd_lat = 70;
    rx(1, 32'h0500_0080);
    tick();
    rx(0, 0);
    get_tx("to hdr", 32'h0500_A000, 0, w);
    tick();
    chk("to strobe", {reg_rd_en_o, reg_addr_o}, {1'b1, 16'h0500});
    tx_ready_i = 1'b0;
    get_tx("to data", 32'hDEAD_BEEF, 1, w);
    chk("to lat", 64'(w), 66);
    chk("to pulse", 64'(rd_timeout_o), 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("to hold", {tx_valid_o, tx_last_o, rd_timeout_o, tx_data_o}, {3'b110, 32'hDEAD_BEEF});
    end
    tx_ready_i = 1'b1;
    tick();
    chk("to done", {tx_valid_o, busy_o}, 0);
    rd_lat = 5;
    rx(1, 32'h0600_0080);
    tick();
    rx(0, 0);
    get_tx("bz hdr", 32'h0600_A000, 0, w);
    tick();
    rx(1, 32'h0100_0001);
    tick();
    chk("bz err", 64'(cmd_err_o), 1);
    rx(1, 32'hCAFE);
    tick();
    chk("bz once", {cmd_err_o, reg_wr_en_o}, 0);
    rx(0, 0);
    get_tx("bz data", dm(16'h0600), 1, w);
    tick();
    chk("bz done", {tx_valid_o, busy_o, cmd_err_o, reg_wr_en_o}, 0);
    rd_lat = 1;
    rx(1, 32'h0700_0081);
    tick();
    rx(0, 0);
    get_tx("rs hdr", 32'h0700_A001, 0, w);
    tick();
    tx_ready_i = 1'b0;
    get_tx("rs data", dm(16'h0700), 0, w);
    tick();
    tick();
    chk("rs hold", {tx_valid_o, busy_o}, 2'b11);
    rst_i = 1'b1;
    tick();
    chk("rs outs", outs(), 0);
    rst_i = 1'b0;
    tx_ready_i = 1'b1;
    rx(1, 32'h0800_0000);
    tick();
    rx(1, 32'h77);
    tick();
    chk("rs wr", {reg_wr_en_o, reg_addr_o, reg_wr_data_o}, {1'b1, 16'h0800, 32'h77});
    rx(0, 0);
    tick();
    rx(1, 32'hFFFF_0001);
    tick();
    rx(1, 32'h1);
    tick();
    chk("wrap0", {reg_wr_en_o, reg_addr_o, reg_wr_data_o}, {1'b1, 16'hFFFF, 32'h1});
    rx(1, 32'h2);
    tick();
    chk("wrap1", {reg_wr_en_o, reg_addr_o, reg_wr_data_o}, {1'b1, 16'h0000, 32'h2});
    rx(0, 0);
    tick();
    chk("wrap done", {reg_wr_en_o, cmd_err_o, busy_o}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_cmd_dispatch.md
# serial_cmd_dispatch

Command sequencer between the serial packet receiver and the register file / serial transmitter, in the `clk_i` domain. The receiver delivers CRC-checked packets as a contiguous word burst. This block parses the header word and acts on the packet type:
- **Write packets:** sequenced into register writes.
- **Read packets:** turned into register reads, with the results returned as a readback packet to the serial transmitter.
- **Slave readback packets:** forwarded unchanged to a readback sink.

## Interface
Parameters:
- `TCQ`, 0.1, simulation clock-to-q delay.
- `ADDR_WIDTH`, 16, register address width; address field is header[31:16].
- `RD_TIMEOUT`, 64, cycles to wait for `reg_rd_vld_i` before substituting `RD_DUMMY`.
- `RD_DUMMY`, 32'hDEAD_BEEF, data substituted on read timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  input  1  system clock.
- `rst_i`  input  1  synchronous, active-high reset.
- `rx_valid_i`  input  1  packet word valid; a packet is a contiguous burst and has no backpressure.
- `rx_data_i`  input  32  packet word; the first word of a burst is the header.
- `reg_wr_en_o`  output  1  register write strobe, one cycle per word.
- `reg_rd_en_o`  output  1  register read strobe, one cycle.
- `reg_addr_o`  output  ADDR_WIDTH  register address.
- `reg_wr_data_o`  output  32  write data.
- `reg_rd_vld_i`  input  1  read data valid, no earlier than 1 cycle after `reg_rd_en_o`.
- `reg_rd_data_i`  input  32  read data.
- `tx_valid_o`  output  1  readback word valid.
- `tx_data_o`  output  32  readback word.
- `tx_last_o`  output  1  final word of the readback packet.
- `tx_ready_i`  input  1  transmitter accepts the word while `tx_valid_o` is high.
- `rb_valid_o`  output  1  slave-readback word valid.
- `rb_data_o`  output  32  slave-readback word.
- `busy_o`  output  1  high in any state other than IDLE.
- `cmd_err_o`  output  1  one-cycle error pulse.
- `rd_timeout_o`  output  1  one-cycle pulse when `RD_DUMMY` is substituted.

## Operation
Header fields:
- [31:16] base address (BA).
- [15:12] type; 4'b1010 marks a slave readback packet.
- [7] read flag.
- [4:0] N-1, where N is the word count.

Header classification, in priority order:
- If type = 1010, go to RB.
- Else if [7] = 1, it is a read; go to RD_HDR.
- Else it is a write; go to WR.

States:
- **IDLE**
  - Waits for `rx_valid_i`.
  - Latches BA and N.
  - Clears the word counter `idx` (6 bits) and the timeout counter.
- **WR**
  - Each data word produces `reg_wr_en_o` = 1, `reg_addr_o` = BA+idx (mod 2^ADDR_WIDTH) and `reg_wr_data_o` = word; then `idx` increments.
  - Returns to IDLE after N words.
- **RB**
  - Each word, including the header, is driven on `rb_valid_o` / `rb_data_o`.
  - Returns to IDLE when the burst ends (`rx_valid_i` = 0).
- **RD_HDR**
  - Drives `tx_data_o` = {BA, 4'b1010, 7'd0, N-1[4:0]} with `tx_last_o` = 0.
  - Goes to RD_REQ on `tx_ready_i`.
- **RD_REQ**
  - Pulses `reg_rd_en_o` for one cycle with `reg_addr_o` = BA+idx.
  - Goes to RD_WAIT.
- **RD_WAIT**
  - On `reg_rd_vld_i`: captures `reg_rd_data_i` and goes to RD_SEND.
  - If the timeout counter reaches `RD_TIMEOUT` first: captures `RD_DUMMY`, pulses `rd_timeout_o` and goes to RD_SEND.
- **RD_SEND**
  - Presents the captured word; `tx_last_o` = (idx == N-1).
  - On `tx_ready_i`: if last, go to IDLE; else increment `idx` and go to RD_REQ.

Boundary rules:
- **Write packet ends early.** If `rx_valid_i` drops in WR before N words, pulse `cmd_err_o` and go to IDLE. The words already written are not rolled back.
- **Write packet runs long.** Words beyond N in the same burst are dropped, with one `cmd_err_o` pulse.
- **Burst arrives while busy.** Applies to `rx_valid_i` in any RD_* state. The whole burst is discarded, `cmd_err_o` pulses once on the first word of the burst, and the read in progress continues unaffected.
- **Header only, then burst ends.** A write header with no data words is handled as a write packet that ended early: `cmd_err_o` pulses.
- **Read data outside RD_WAIT.** `reg_rd_vld_i` arriving in any other state is ignored. A late response that arrives after a timeout is therefore dropped.
- **tx handshake.** While `tx_valid_o` is high, `tx_data_o` and `tx_last_o` hold stable until `tx_ready_i`.
- **Reset.** `rst_i` in any state returns to IDLE next cycle and drops `tx_valid_o` immediately; reset overrides the handshake.

## Timing
- All outputs are registered and reset to 0.
- **Write:** header at cycle n, data word k at cycle n+1+k, `reg_wr_en_o` for word k at cycle n+2+k. Throughput is 1 write per cycle.
- **Readback forwarding:** `rb_valid_o` follows `rx_valid_i` with 1 cycle latency.
- **Read header:** `tx_valid_o` goes high at cycle n+2 after a header at cycle n.
- **Per read word:**
  - `reg_rd_en_o` is asserted the cycle after the tx accept.
  - `tx_valid_o` is asserted the cycle after `reg_rd_vld_i`.
  - Minimum 3 cycles per word with `tx_ready_i` held at 1.
- **Timeout:** counter clears in RD_REQ and counts RD_WAIT cycles. Substitution happens on the cycle where count == `RD_TIMEOUT`.
- `busy_o` is high from the cycle after the header until the cycle IDLE is re-entered.

## Test plan
- **Write burst:** header 32'h0100_0003, then 4 words A0..A3 → writes to 0x0100..0x0103 with data A0..A3 on 4 consecutive cycles; `cmd_err_o` = 0.
- **Read, fixed latency:** header 32'h0200_0081 (N=2), `reg_rd_vld_i` 2 cycles after each strobe, `tx_ready_i` = 1 → tx words 32'h0200_A001, D(0x0200), D(0x0201) with `tx_last_o` on the third word.
- **Read timeout and backpressure:** N=1 read with `reg_rd_vld_i` never asserted → `rd_timeout_o` pulse after 64 wait cycles and tx data 32'hDEAD_BEEF. With `tx_ready_i` held low for 10 cycles, data stays stable throughout.
- **Readback forwarding:** burst 32'h1234_A000, 32'h5555_5555 → `rb_valid_o` for 2 cycles with identical data; no register strobes.
- **Error cases:**
  - Write header N=4 with only 2 data words → 2 writes, then a `cmd_err_o` pulse.
  - A new burst during RD_WAIT → dropped, one `cmd_err_o` pulse, and the read completes correctly.
- **Reset and address wrap:** `rst_i` asserted during RD_SEND → all outputs 0 next cycle, then an immediate new write works. Write with BA 0xFFFF, N=2 → addresses 0xFFFF, then 0x0000.
